// File: rtl/ranged_delay_checker_rtl.sv
// -----------------------------------------------------------------------------
// ranged_delay_checker_rtl
//
// Multi-channel checker for the property  a[i] |-> ##[MIN_DLY:MAX_DLY] b[i].
// Every channel tracks any number of overlapping attempts and reports
// registered per-edge pass/fail pulses, an "attempt pending" flag, saturating
// pass/fail counters and a sticky failure flag. The block only observes the
// design under check; it never drives anything back into it.
//
// Parameters
//   N_CH     number of independent channels
//   MIN_DLY  lower window bound in cycles (0 allowed)
//   MAX_DLY  upper window bound in cycles, 1..32, MIN_DLY <= MAX_DLY
//   CNT_W    width of every pass/fail counter
//
// Ports
//   clk               sampling clock, everything happens on the rising edge
//   rst_n             asynchronous active-low reset, discards all attempts
//   en                allows a to start new attempts (pending ones keep going)
//   clr               synchronous clear of attempts, counters, sticky flags
//   a[N_CH]           antecedent per channel
//   b[N_CH]           consequent per channel
//   assertion_pass    1-cycle pulse: at least one attempt passed at the edge
//   assertion_fail    1-cycle pulse: an attempt expired at the edge
//   assertion_active  at least one attempt still pending
//   fail_sticky       set by any failure, held until clr or reset
//   pass_cnt          per-channel passed-attempt count, ch i at [i*CNT_W +: CNT_W]
//   fail_cnt          per-channel failed-attempt count, same packing
//
// Attempt bookkeeping
//   Each channel keeps a MAX_DLY-bit vector r_pend. Bit j set after an edge
//   means "an attempt of age j is pending". At the next edge that attempt is
//   one cycle older, so the ages evaluated at an edge form the vector
//   {r_pend, new_start}, where bit k holds the attempt of age k (0..MAX_DLY).
//   An attempt of age MAX_DLY is always resolved at that edge (pass on b=1,
//   fail on b=0), which is why MAX_DLY bits of storage suffice.
// -----------------------------------------------------------------------------
module ranged_delay_checker_rtl #(
    parameter int N_CH    = 4,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 4,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic [N_CH-1:0]         a,
    input  logic [N_CH-1:0]         b,
    output logic [N_CH-1:0]         assertion_pass,
    output logic [N_CH-1:0]         assertion_fail,
    output logic [N_CH-1:0]         assertion_active,
    output logic [N_CH-1:0]         fail_sticky,
    output logic [N_CH*CNT_W-1:0]   pass_cnt,
    output logic [N_CH*CNT_W-1:0]   fail_cnt
);

    // -------------------------------------------------------------------------
    // Parameter legality: an illegal window stops elaboration.
    // -------------------------------------------------------------------------
    if (MAX_DLY < 1 || MAX_DLY > 32 || MIN_DLY < 0 || MIN_DLY > MAX_DLY ||
        N_CH < 1 || CNT_W < 1) begin : g_bad_params
        $error("ranged_delay_checker_rtl: illegal parameters N_CH=%0d MIN_DLY=%0d MAX_DLY=%0d CNT_W=%0d",
               N_CH, MIN_DLY, MAX_DLY, CNT_W);
    end

    // Ages MIN_DLY..MAX_DLY are inside the window.
    localparam logic [MAX_DLY:0] WIN_MASK = {(MAX_DLY + 1){1'b1}} << MIN_DLY;

    // Up to MAX_DLY+1 attempts can pass on one edge.
    localparam int POP_W = $clog2(MAX_DLY + 2);

    // Wide enough that counter + popcount can never overflow before saturation.
    localparam int SUM_W = CNT_W + POP_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // -------------------------------------------------------------------------
    // Per-channel checker
    // -------------------------------------------------------------------------
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch

        logic [MAX_DLY-1:0] r_pend;
        logic               r_pass;
        logic               r_fail;
        logic               r_active;
        logic               r_sticky;
        logic [CNT_W-1:0]   r_pass_cnt;
        logic [CNT_W-1:0]   r_fail_cnt;

        logic [MAX_DLY:0]   w_age;        // attempts present at this edge, by age
        logic [MAX_DLY:0]   w_hit;        // attempts discharged by b this edge
        logic               w_expire;     // oldest attempt saw b=0
        logic [MAX_DLY-1:0] w_pend_nxt;
        logic [POP_W-1:0]   w_pass_num;
        logic [SUM_W-1:0]   w_pass_sum;
        logic [CNT_W-1:0]   w_pass_cnt_nxt;
        logic [CNT_W-1:0]   w_fail_cnt_nxt;

        // NOTE: every signal assigned in always_comb gets a default on entry, so
        // no path can leave it unassigned and infer a latch.
        always_comb begin
            w_age          = '0;
            w_hit          = '0;
            w_expire       = 1'b0;
            w_pend_nxt     = '0;
            w_pass_num     = '0;
            w_pass_sum     = '0;
            w_pass_cnt_nxt = r_pass_cnt;
            w_fail_cnt_nxt = r_fail_cnt;

            // Age 0 is a start on this very edge; older ages come from storage.
            w_age = {r_pend, a[ch] & en};

            if (b[ch]) begin
                // One b pulse discharges every attempt inside the window;
                // younger attempts ignore it and stay pending.
                w_hit = w_age & WIN_MASK;
            end else begin
                // Only the age-MAX_DLY attempt can expire, and at most one
                // exists because starts are one per edge.
                w_expire = w_age[MAX_DLY];
            end

            // Survivors age by one; age MAX_DLY never survives (passed or failed).
            w_pend_nxt = w_age[MAX_DLY-1:0] & ~w_hit[MAX_DLY-1:0];

            // Saturating counter updates.
            w_pass_num = POP_W'($countones(w_hit));
            w_pass_sum = SUM_W'(r_pass_cnt) + SUM_W'(w_pass_num);
            if (w_pass_sum > SUM_W'(CNT_MAX)) begin
                w_pass_cnt_nxt = CNT_MAX;
            end else begin
                w_pass_cnt_nxt = w_pass_sum[CNT_W-1:0];
            end

            if (w_expire && (r_fail_cnt != CNT_MAX)) begin
                w_fail_cnt_nxt = r_fail_cnt + CNT_W'(1);
            end
        end

        // NOTE: state is written with non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        // NOTE: the pending-age vector is reset along with the flags; leaving it
        // unreset would let stale attempts fire after reset is released.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pend     <= '0;
                r_pass     <= 1'b0;
                r_fail     <= 1'b0;
                r_active   <= 1'b0;
                r_sticky   <= 1'b0;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
            end else if (clr) begin
                // clr outranks everything: a and b on this edge are ignored.
                r_pend     <= '0;
                r_pass     <= 1'b0;
                r_fail     <= 1'b0;
                r_active   <= 1'b0;
                r_sticky   <= 1'b0;
                r_pass_cnt <= '0;
                r_fail_cnt <= '0;
            end else begin
                r_pend     <= w_pend_nxt;
                r_pass     <= |w_hit;
                r_fail     <= w_expire;
                r_active   <= |w_pend_nxt;
                r_sticky   <= r_sticky | w_expire;
                r_pass_cnt <= w_pass_cnt_nxt;
                r_fail_cnt <= w_fail_cnt_nxt;
            end
        end

        assign assertion_pass[ch]             = r_pass;
        assign assertion_fail[ch]             = r_fail;
        assign assertion_active[ch]           = r_active;
        assign fail_sticky[ch]                = r_sticky;
        assign pass_cnt[ch*CNT_W +: CNT_W]    = r_pass_cnt;
        assign fail_cnt[ch*CNT_W +: CNT_W]    = r_fail_cnt;

    end : g_ch

endmodule : ranged_delay_checker_rtl

// File: tb/tb_ranged_delay_checker_rtl.sv
// -----------------------------------------------------------------------------
// Testbench for ranged_delay_checker_rtl.
//
// Two instances run side by side:
//   u_dut_main : N_CH=4, MIN_DLY=2, MAX_DLY=4, CNT_W=16
//   u_dut_zero : N_CH=2, MIN_DLY=0, MAX_DLY=1, CNT_W=2  (immediate pass, saturation)
//
// The reference model keeps every live attempt as a record {instance, channel,
// start edge} in one queue. At each edge it derives the age of each attempt from
// the edge number and applies the property rules directly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ranged_delay_checker_rtl;

    // ---------------------------------------------------------------- DUT wiring
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        m_en, m_clr;
    logic [3:0]  m_a, m_b;
    logic [3:0]  m_pass_o, m_fail_o, m_act_o, m_stk_o;
    logic [63:0] m_pcnt_o, m_fcnt_o;

    logic        z_en, z_clr;
    logic [1:0]  z_a, z_b;
    logic [1:0]  z_pass_o, z_fail_o, z_act_o, z_stk_o;
    logic [3:0]  z_pcnt_o, z_fcnt_o;

    ranged_delay_checker_rtl #(
        .N_CH(4), .MIN_DLY(2), .MAX_DLY(4), .CNT_W(16)
    ) u_dut_main (
        .clk(clk), .rst_n(rst_n), .en(m_en), .clr(m_clr), .a(m_a), .b(m_b),
        .assertion_pass(m_pass_o), .assertion_fail(m_fail_o),
        .assertion_active(m_act_o), .fail_sticky(m_stk_o),
        .pass_cnt(m_pcnt_o), .fail_cnt(m_fcnt_o)
    );

    ranged_delay_checker_rtl #(
        .N_CH(2), .MIN_DLY(0), .MAX_DLY(1), .CNT_W(2)
    ) u_dut_zero (
        .clk(clk), .rst_n(rst_n), .en(z_en), .clr(z_clr), .a(z_a), .b(z_b),
        .assertion_pass(z_pass_o), .assertion_fail(z_fail_o),
        .assertion_active(z_act_o), .fail_sticky(z_stk_o),
        .pass_cnt(z_pcnt_o), .fail_cnt(z_fcnt_o)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- bookkeeping
    int n_cmp = 0;
    int n_bad = 0;
    int now   = 0;

    // ---------------------------------------------------------------- model
    typedef struct {
        int inst;
        int ch;
        int t0;
    } attempt_t;

    attempt_t pend_q[$];

    bit exp_pass   [2][4];
    bit exp_fail   [2][4];
    bit exp_act    [2][4];
    bit exp_sticky [2][4];
    int exp_pcnt   [2][4];
    int exp_fcnt   [2][4];

    function automatic int nch(int i);   return (i == 0) ? 4 : 2;         endfunction
    function automatic int min_d(int i); return (i == 0) ? 2 : 0;         endfunction
    function automatic int max_d(int i); return (i == 0) ? 4 : 1;         endfunction
    function automatic int cmax(int i);  return (i == 0) ? 65535 : 3;     endfunction

    function automatic bit in_a(int i, int c);  return (i == 0) ? m_a[c] : z_a[c]; endfunction
    function automatic bit in_b(int i, int c);  return (i == 0) ? m_b[c] : z_b[c]; endfunction
    function automatic bit in_en(int i);        return (i == 0) ? m_en : z_en;     endfunction
    function automatic bit in_clr(int i);       return (i == 0) ? m_clr : z_clr;   endfunction

    task automatic model_reset();
        pend_q.delete();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 4; c++) begin
                exp_pass[i][c]   = 1'b0;
                exp_fail[i][c]   = 1'b0;
                exp_act[i][c]    = 1'b0;
                exp_sticky[i][c] = 1'b0;
                exp_pcnt[i][c]   = 0;
                exp_fcnt[i][c]   = 0;
            end
        end
    endtask

    // One rising edge of the property rules for both instances.
    task automatic model_edge();
        now++;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < nch(i); c++) begin
                int passed;
                bit failed;
                bit act;
                int age;
                passed = 0;
                failed = 1'b0;
                act    = 1'b0;
                if (in_clr(i)) begin
                    for (int k = pend_q.size() - 1; k >= 0; k--)
                        if (pend_q[k].inst == i && pend_q[k].ch == c) pend_q.delete(k);
                    exp_pass[i][c]   = 1'b0;
                    exp_fail[i][c]   = 1'b0;
                    exp_act[i][c]    = 1'b0;
                    exp_sticky[i][c] = 1'b0;
                    exp_pcnt[i][c]   = 0;
                    exp_fcnt[i][c]   = 0;
                    continue;
                end
                if (in_en(i) && in_a(i, c)) pend_q.push_back('{i, c, now});
                for (int k = pend_q.size() - 1; k >= 0; k--) begin
                    if (pend_q[k].inst == i && pend_q[k].ch == c) begin
                        age = now - pend_q[k].t0;
                        if (in_b(i, c) && age >= min_d(i)) begin
                            passed++;
                            pend_q.delete(k);
                        end else if (!in_b(i, c) && age >= max_d(i)) begin
                            failed = 1'b1;
                            pend_q.delete(k);
                        end
                    end
                end
                for (int k = 0; k < pend_q.size(); k++)
                    if (pend_q[k].inst == i && pend_q[k].ch == c) act = 1'b1;
                exp_pass[i][c]   = (passed > 0);
                exp_fail[i][c]   = failed;
                exp_act[i][c]    = act;
                exp_sticky[i][c] = exp_sticky[i][c] | failed;
                exp_pcnt[i][c]   = (exp_pcnt[i][c] + passed > cmax(i)) ? cmax(i) : exp_pcnt[i][c] + passed;
                exp_fcnt[i][c]   = (exp_fcnt[i][c] + int'(failed) > cmax(i)) ? cmax(i) : exp_fcnt[i][c] + int'(failed);
            end
        end
    endtask

    // Output bundles: {pass, fail, active, sticky, pass_cnt, fail_cnt}
    function automatic logic [143:0] exp_main();
        logic [3:0]  p, f, ac, s;
        logic [63:0] pc, fc;
        for (int c = 0; c < 4; c++) begin
            p[c]  = exp_pass[0][c];
            f[c]  = exp_fail[0][c];
            ac[c] = exp_act[0][c];
            s[c]  = exp_sticky[0][c];
            pc[c*16 +: 16] = 16'(exp_pcnt[0][c]);
            fc[c*16 +: 16] = 16'(exp_fcnt[0][c]);
        end
        return {p, f, ac, s, pc, fc};
    endfunction

    function automatic logic [143:0] obs_main();
        return {m_pass_o, m_fail_o, m_act_o, m_stk_o, m_pcnt_o, m_fcnt_o};
    endfunction

    function automatic logic [15:0] exp_zero();
        logic [1:0] p, f, ac, s;
        logic [3:0] pc, fc;
        for (int c = 0; c < 2; c++) begin
            p[c]  = exp_pass[1][c];
            f[c]  = exp_fail[1][c];
            ac[c] = exp_act[1][c];
            s[c]  = exp_sticky[1][c];
            pc[c*2 +: 2] = 2'(exp_pcnt[1][c]);
            fc[c*2 +: 2] = 2'(exp_fcnt[1][c]);
        end
        return {p, f, ac, s, pc, fc};
    endfunction

    function automatic logic [15:0] obs_zero();
        return {z_pass_o, z_fail_o, z_act_o, z_stk_o, z_pcnt_o, z_fcnt_o};
    endfunction

    // ---------------------------------------------------------------- stimulus
    task automatic idle();
        m_a = '0; m_b = '0; m_en = 1'b1; m_clr = 1'b0;
        z_a = '0; z_b = '0; z_en = 1'b1; z_clr = 1'b0;
    endtask

    // Advance one edge; model evaluates the same sampled inputs; sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_clr();
        idle();
        m_clr = 1'b1;
        z_clr = 1'b1;
        tick();
        idle();
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_main() !== '0) begin
            n_bad++;
            $display("FAIL reset/main: got %h want 0", obs_main());
        end
        n_cmp++;
        if (obs_zero() !== '0) begin
            n_bad++;
            $display("FAIL reset/zero: got %h want 0", obs_zero());
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        n_cmp++;
        if (obs_main() !== exp_main()) begin
            n_bad++;
            $display("FAIL reset/first_edge: got %h want %h", obs_main(), exp_main());
        end
    endtask

    // a at edge 0, b at edge 3 on channel 0 (MIN=2, MAX=4).
    task automatic test_single_pass();
        do_clr();
        for (int e = 0; e < 4; e++) begin
            m_a = (e == 0) ? 4'b0001 : 4'b0000;
            m_b = (e == 3) ? 4'b0001 : 4'b0000;
            tick();
            n_cmp++;
            if (obs_main() !== exp_main()) begin
                n_bad++;
                $display("FAIL single_pass/model edge %0d: got %h want %h", e, obs_main(), exp_main());
            end
            n_cmp++;
            if (m_act_o !== ((e < 3) ? 4'b0001 : 4'b0000)) begin
                n_bad++;
                $display("FAIL single_pass/active edge %0d: got %b want %b", e, m_act_o, (e < 3) ? 4'b0001 : 4'b0000);
            end
        end
        n_cmp++;
        if (m_pass_o !== 4'b0001 || m_pcnt_o !== 64'd1 || m_fail_o !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_pass/result: pass=%b pcnt=%h fail=%b want 0001 1 0000", m_pass_o, m_pcnt_o, m_fail_o);
        end
        idle();
        tick();
        n_cmp++;
        if (m_pass_o !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_pass/pulse_width: got %b want 0000", m_pass_o);
        end
    endtask

    // b too early (age 1) leaves the attempt pending; it expires at age 4.
    task automatic test_too_early();
        do_clr();
        for (int e = 0; e < 8; e++) begin
            m_a = (e == 0) ? 4'b0001 : 4'b0000;
            m_b = (e == 1) ? 4'b0001 : 4'b0000;
            tick();
            n_cmp++;
            if (obs_main() !== exp_main()) begin
                n_bad++;
                $display("FAIL too_early/model edge %0d: got %h want %h", e, obs_main(), exp_main());
            end
            n_cmp++;
            if (m_fail_o[0] !== (e == 4) || m_stk_o[0] !== (e >= 4) || m_pass_o[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL too_early/flags edge %0d: fail=%b sticky=%b pass=%b want %b %b 0",
                         e, m_fail_o[0], m_stk_o[0], m_pass_o[0], e == 4, e >= 4);
            end
        end
        n_cmp++;
        if (m_fcnt_o[15:0] !== 16'd1) begin
            n_bad++;
            $display("FAIL too_early/fail_cnt: got %0d want 1", m_fcnt_o[15:0]);
        end
        do_clr();
        n_cmp++;
        if (m_stk_o !== 4'b0000 || m_fcnt_o !== 64'd0) begin
            n_bad++;
            $display("FAIL too_early/clr: sticky=%b fcnt=%h want 0000 0", m_stk_o, m_fcnt_o);
        end
    endtask

    // b at exactly MAX_DLY passes; b one cycle after MAX_DLY is too late.
    task automatic test_boundary();
        do_clr();
        for (int e = 0; e < 11; e++) begin
            m_a = (e == 0 || e == 5) ? 4'b0001 : 4'b0000;
            m_b = (e == 4 || e == 10) ? 4'b0001 : 4'b0000;
            tick();
            n_cmp++;
            if (obs_main() !== exp_main()) begin
                n_bad++;
                $display("FAIL boundary/model edge %0d: got %h want %h", e, obs_main(), exp_main());
            end
            n_cmp++;
            if (m_pass_o[0] !== (e == 4) || m_fail_o[0] !== (e == 9)) begin
                n_bad++;
                $display("FAIL boundary/pulses edge %0d: pass=%b fail=%b want %b %b",
                         e, m_pass_o[0], m_fail_o[0], e == 4, e == 9);
            end
        end
        n_cmp++;
        if (m_pcnt_o[15:0] !== 16'd1 || m_fcnt_o[15:0] !== 16'd1) begin
            n_bad++;
            $display("FAIL boundary/counts: pcnt=%0d fcnt=%0d want 1 1", m_pcnt_o[15:0], m_fcnt_o[15:0]);
        end
    endtask

    // Three overlapping attempts (ages 4,3,2 at the b edge) all discharge at once.
    task automatic test_overlap();
        do_clr();
        for (int e = 0; e < 6; e++) begin
            m_a = (e <= 2) ? 4'b0001 : 4'b0000;
            m_b = (e == 4) ? 4'b0001 : 4'b0000;
            tick();
            n_cmp++;
            if (obs_main() !== exp_main()) begin
                n_bad++;
                $display("FAIL overlap/model edge %0d: got %h want %h", e, obs_main(), exp_main());
            end
            n_cmp++;
            if (m_pass_o[0] !== (e == 4) || m_act_o[0] !== (e < 4) || m_fail_o[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL overlap/flags edge %0d: pass=%b act=%b fail=%b want %b %b 0",
                         e, m_pass_o[0], m_act_o[0], m_fail_o[0], e == 4, e < 4);
            end
        end
        n_cmp++;
        if (m_pcnt_o[15:0] !== 16'd3) begin
            n_bad++;
            $display("FAIL overlap/pass_cnt: got %0d want 3", m_pcnt_o[15:0]);
        end
    endtask

    // MIN_DLY=0: a=b=1 passes immediately, never pending; CNT_W=2 saturates at 3.
    task automatic test_min_zero();
        do_clr();
        for (int e = 0; e < 5; e++) begin
            z_a = 2'b01;
            z_b = 2'b01;
            tick();
            n_cmp++;
            if (obs_zero() !== exp_zero()) begin
                n_bad++;
                $display("FAIL min_zero/model edge %0d: got %h want %h", e, obs_zero(), exp_zero());
            end
            n_cmp++;
            if (z_pass_o !== 2'b01 || z_act_o !== 2'b00) begin
                n_bad++;
                $display("FAIL min_zero/flags edge %0d: pass=%b act=%b want 01 00", e, z_pass_o, z_act_o);
            end
        end
        n_cmp++;
        if (z_pcnt_o !== 4'b0011) begin
            n_bad++;
            $display("FAIL min_zero/saturate: got %b want 0011", z_pcnt_o);
        end
    endtask

    // Mid-cycle reset drops pending attempts; clr drops them and ignores b.
    task automatic test_reset_and_clr();
        // Counters from earlier tests are still non-zero here.
        idle();
        m_a = 4'b0001;
        tick();
        idle();
        tick();
        tick();                     // attempt now pending at age 2
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_main() !== '0 || obs_zero() !== '0) begin
            n_bad++;
            $display("FAIL reset_mid/outputs: main=%h zero=%h want 0", obs_main(), obs_zero());
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            n_cmp++;
            if (m_fail_o !== 4'b0000 || obs_main() !== exp_main()) begin
                n_bad++;
                $display("FAIL reset_mid/no_fail edge %0d: got %h want %h", e, obs_main(), exp_main());
            end
        end
        // ch1 passes (nonzero counter), ch0 left pending, then clr with b=1.
        m_a = 4'b0011;
        tick();
        idle();
        tick();
        m_b = 4'b0010;
        tick();
        n_cmp++;
        if (m_pcnt_o[31:16] !== 16'd1 || m_act_o !== 4'b0001) begin
            n_bad++;
            $display("FAIL clr_setup: pcnt1=%0d act=%b want 1 0001", m_pcnt_o[31:16], m_act_o);
        end
        m_b   = 4'b0001;
        m_clr = 1'b1;
        tick();
        n_cmp++;
        if (m_pass_o !== 4'b0000 || m_pcnt_o !== 64'd0 || m_act_o !== 4'b0000 || obs_main() !== exp_main()) begin
            n_bad++;
            $display("FAIL clr/priority: pass=%b pcnt=%h act=%b want 0000 0 0000", m_pass_o, m_pcnt_o, m_act_o);
        end
        idle();
        for (int e = 0; e < 6; e++) begin
            tick();
            n_cmp++;
            if (m_fail_o !== 4'b0000) begin
                n_bad++;
                $display("FAIL clr/no_fail edge %0d: got %b want 0000", e, m_fail_o);
            end
        end
    endtask

    // Random traffic on both instances, including en=0 and occasional clr.
    task automatic test_random();
        do_clr();
        for (int n = 0; n < 800; n++) begin
            m_a   = 4'($urandom & $urandom);
            m_b   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom & $urandom);
            m_en  = ($urandom_range(0, 7) != 0);
            m_clr = ($urandom_range(0, 99) == 0);
            z_a   = 2'($urandom);
            z_b   = 2'($urandom);
            z_en  = ($urandom_range(0, 5) != 0);
            z_clr = ($urandom_range(0, 99) == 0);
            tick();
            n_cmp++;
            if (obs_main() !== exp_main()) begin
                n_bad++;
                $display("FAIL random/main step %0d: got %h want %h", n, obs_main(), exp_main());
            end
            n_cmp++;
            if (obs_zero() !== exp_zero()) begin
                n_bad++;
                $display("FAIL random/zero step %0d: got %h want %h", n, obs_zero(), exp_zero());
            end
        end
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        idle();
        model_reset();
        test_reset();
        test_single_pass();
        test_too_early();
        test_boundary();
        test_overlap();
        test_min_zero();
        test_reset_and_clr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

endmodule : tb_ranged_delay_checker_rtl

// File: doc/ranged_delay_checker_rtl.md
Name: ranged_delay_checker_rtl

Overview:
Multi-channel synthesizable checker for the property a[i] |-> ##[MIN_DLY:MAX_DLY] b[i]. It is the parametrised successor of the fixed-delay checker flow. Each channel tracks any number of overlapping attempts and reports per-edge pass/fail pulses, an active flag, saturating pass/fail counters and a sticky failure flag. It sits beside the design under check in the same sampled-clock domain and has no influence on it.

Parameters:
N_CH, 4, number of independent channels
MIN_DLY, 1, lower window bound in cycles (0 allowed)
MAX_DLY, 4, upper window bound in cycles; legal when 1 <= MAX_DLY <= 32 and MIN_DLY <= MAX_DLY, else elaboration error
CNT_W, 16, width of each pass/fail counter

Ports:
clk  input  1  sampling clock; all behaviour on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
en  input  1  when 1, a may start attempts; pending attempts keep evolving regardless
clr  input  1  synchronous clear of attempts, counters and sticky flags
a  input  N_CH  antecedent per channel
b  input  N_CH  consequent per channel
assertion_pass  output  N_CH  1-cycle pulse, one or more attempts passed
assertion_fail  output  N_CH  1-cycle pulse, an attempt expired
assertion_active  output  N_CH  at least one attempt pending
fail_sticky  output  N_CH  set on any fail, held until clr/reset
pass_cnt  output  N_CH*CNT_W  per-channel passed-attempt count, channel i at [i*CNT_W +: CNT_W]
fail_cnt  output  N_CH*CNT_W  per-channel failed-attempt count, same packing

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, counters 0, all pending attempts discarded. First evaluation happens at the first rising edge after rst_n is 1.
- Channels are fully independent; the description below is per channel.
- Attempt start: a=1 and en=1 sampled at edge T0 starts an attempt of age 0.
- Window: the attempt passes at the first edge T0+k with b=1 and MIN_DLY <= k <= MAX_DLY.
  - b=1 at k < MIN_DLY has no effect on that attempt.
  - MIN_DLY=0 with a=b=1 at T0 is an immediate pass; no pending state is created.
- Expiry: if b=0 at edge T0+MAX_DLY, the attempt fails at that edge and is dropped.
- A single b=1 edge discharges every pending attempt whose age is inside the window. Ages below MIN_DLY stay pending.
- Pass and fail are mutually exclusive on one edge: fail requires b=0, pass requires b=1. b=1 at exactly age MAX_DLY is a pass.
- At most one attempt can expire per edge, because starts are at most one per edge.
- Outputs are registered. The pass/fail pulse for an event evaluated at edge E is high from E until E+1.
- assertion_pass=1 if at least one attempt passed at that edge.
  - pass_cnt increases by the number of attempts passed at that edge, popcount of up to MAX_DLY+1.
  - pass_cnt saturates at 2^CNT_W-1 and never wraps.
- assertion_fail=1 if an attempt expired.
  - fail_cnt increases by 1, saturating.
  - fail_sticky is set to 1.
- assertion_active is registered: 1 after edge E iff some attempt is still pending after E's evaluation. It stays 0 for an immediate MIN_DLY=0 pass with no other pending attempts.
- Storage: a pending-age bit vector of MAX_DLY bits per channel; an attempt's age increments every edge.
- clr=1 at an edge:
  - pending attempts, counters and fail_sticky go to 0;
  - pass/fail pulses are 0 for that edge;
  - a and b at that edge are ignored.
  - clr has priority over all other events.
- en=0: no new attempts start; existing attempts still pass or fail normally.
- Reset mid-operation: pending attempts vanish. No fail is reported for them at any later time.

Test Plan:
1. N_CH=4, MIN=2, MAX=4; ch0 a=1 at edge 10, b=1 at edge 13 -> assertion_pass[0]=1 during cycle after edge 13; pass_cnt[0]=1; assertion_active[0]=1 after edges 10-12, 0 after edge 13; other channels stay 0.
2. Same config; a=1 at edge 10, b=1 only at edge 11 (too early) -> assertion_fail[0] pulse after edge 14; fail_cnt[0]=1; fail_sticky[0]=1 until clr.
3. Boundary: a at edge 10, b=1 first at edge 14 -> pass, not fail. a at edge 20, b=1 at edge 25 -> fail after edge 24, no pass at 25.
4. Overlap: a=1 at edges 10, 11, 12; b=1 at edge 14 only -> single pass pulse after edge 14; pass_cnt increments by 3 (ages 4, 3, 2); active 0 after edge 14.
5. MIN=0, MAX=1; a=b=1 at edge 5 -> pass pulse after edge 5, active stays 0. CNT_W=2 with 5 such passes -> pass_cnt=3 (saturated).
6. Attempt pending at age 2; rst_n driven low mid-cycle -> all outputs 0 immediately; after release with b=0 for 10 edges -> no fail. Separately, clr at edge with pending attempts and b=1 -> no pass, counters 0.
